// File: rtl/ball_renderer.sv
// ball_renderer: pixel stage after the VGA timing generator; square ball over a solid background.
// Latency: RGB, hsync_out and vsync_out are exactly 2 pxl_clk cycles behind their inputs.
// Backpressure: none; free-running pixel stream, one pixel accepted every pxl_clk cycle.
//
// Ports:
//   pxl_clk, reset_n (async, active-low)
//   hcount, vcount, hsync_in, vsync_in : raster position and syncs from the timing generator
//   run                                : motion enable, only looked at on frame_tick
//   red, green, blue                   : 4-bit colour channels
//   hsync_out, vsync_out               : syncs delayed to line up with RGB
//   frame_tick                         : one-cycle pulse when vcount first reaches V_ACTIVE
//   bounce                             : one-cycle pulse when the ball reflects off a wall
//   ball_x, ball_y                     : top-left corner of the ball
//
// Option: define BALL_RENDERER_BORDER_EN to draw an 8-pixel white frame inside the active
// area and pull the walls in by 8 on every side.
module ball_renderer #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BALL_SIZE = 16,
  parameter int          SPEED     = 2,
  parameter logic [11:0] BALL_RGB  = 12'hF80,
  parameter logic [11:0] BG_RGB    = 12'h008
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       run,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic       bounce,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y
);

`ifdef BALL_RENDERER_BORDER_EN
  localparam int BORDER = 8;
`else
  localparam int BORDER = 0;
`endif

  // All position arithmetic is 11 bits wide so pos + SPEED can never wrap.
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] BSIZE = 11'(BALL_SIZE);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] X_MIN = 11'(BORDER);
  localparam logic [10:0] Y_MIN = 11'(BORDER);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BORDER - BALL_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BORDER - BALL_SIZE);
  localparam logic [10:0] X_LO  = X_MIN + SPD;
  localparam logic [10:0] Y_LO  = Y_MIN + SPD;
  localparam logic [9:0]  X_CTR = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR = 10'((V_ACTIVE - BALL_SIZE) / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        dx;
  logic        dy;
  logic        dx_d;
  logic        dy_d;
  logic [9:0]  x_d;
  logic [9:0]  y_d;
  logic        bounce_d;
  logic [9:0]  vcount_d;

  logic [10:0] h_wide;
  logic [10:0] v_wide;
  logic [10:0] x_wide;
  logic [10:0] y_wide;
  logic [10:0] x_inc;
  logic [10:0] x_dec;
  logic [10:0] y_inc;
  logic [10:0] y_dec;

  assign h_wide = {1'b0, hcount};
  assign v_wide = {1'b0, vcount};
  assign x_wide = {1'b0, ball_x};
  assign y_wide = {1'b0, ball_y};
  assign x_inc  = x_wide + SPD;
  assign x_dec  = x_wide - SPD;
  assign y_inc  = y_wide + SPD;
  assign y_dec  = y_wide - SPD;

  // Start of vblank: fires once on the transition into V_ACTIVE; a held value does not retrigger.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      vcount_d   <= '0;
      frame_tick <= 1'b0;
    end else begin
      vcount_d   <= vcount;
      frame_tick <= (v_wide == V_ACT) && (vcount_d != vcount);
    end
  end

  // Motion control. Everything is gated by frame_tick so the ball only moves during vblank.
  always_comb begin
    state_d  = state_q;
    x_d      = ball_x;
    y_d      = ball_y;
    dx_d     = dx;
    dy_d     = dy;
    bounce_d = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (run) state_d = MOVE;
        end
        MOVE: begin
          if (run) begin
            if (!dx) begin
              if (x_inc >= X_MAX) begin
                x_d      = X_MAX[9:0];
                dx_d     = 1'b1;
                bounce_d = 1'b1;
              end else begin
                x_d = x_inc[9:0];
              end
            end else begin
              if (x_wide <= X_LO) begin
                x_d      = X_MIN[9:0];
                dx_d     = 1'b0;
                bounce_d = 1'b1;
              end else begin
                x_d = x_dec[9:0];
              end
            end
            if (!dy) begin
              if (y_inc >= Y_MAX) begin
                y_d      = Y_MAX[9:0];
                dy_d     = 1'b1;
                bounce_d = 1'b1;
              end else begin
                y_d = y_inc[9:0];
              end
            end else begin
              if (y_wide <= Y_LO) begin
                y_d      = Y_MIN[9:0];
                dy_d     = 1'b0;
                bounce_d = 1'b1;
              end else begin
                y_d = y_dec[9:0];
              end
            end
          end else begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (run) state_d = MOVE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ball_x  <= X_CTR;
      ball_y  <= Y_CTR;
      dx      <= 1'b0;
      dy      <= 1'b0;
      bounce  <= 1'b0;
    end else begin
      state_q <= state_d;
      ball_x  <= x_d;
      ball_y  <= y_d;
      dx      <= dx_d;
      dy      <= dy_d;
      bounce  <= bounce_d;
    end
  end

  // Stage 1: region compares against the ball position held for the current pixel.
  logic active_c;
  logic ball_c;
  logic active_s1;
  logic ball_s1;
  logic hsync_s1;
  logic vsync_s1;

  assign active_c = (h_wide < H_ACT) && (v_wide < V_ACT);
  assign ball_c   = (h_wide >= x_wide) && (h_wide < x_wide + BSIZE) &&
                    (v_wide >= y_wide) && (v_wide < y_wide + BSIZE);

`ifdef BALL_RENDERER_BORDER_EN
  localparam logic [10:0] BW   = 11'(BORDER);
  localparam logic [10:0] H_IN = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] V_IN = 11'(V_ACTIVE - BORDER);
  logic border_c;
  logic border_s1;
  assign border_c = (h_wide < BW) || (h_wide >= H_IN) || (v_wide < BW) || (v_wide >= V_IN);
`endif

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      active_s1 <= 1'b0;
      ball_s1   <= 1'b0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
`ifdef BALL_RENDERER_BORDER_EN
      border_s1 <= 1'b0;
`endif
    end else begin
      active_s1 <= active_c;
      ball_s1   <= ball_c;
      hsync_s1  <= hsync_in;
      vsync_s1  <= vsync_in;
`ifdef BALL_RENDERER_BORDER_EN
      border_s1 <= border_c;
`endif
    end
  end

  // Stage 2: colour priority is blanking, then ball, then border, then background.
  logic [11:0] rgb_c;
  logic [11:0] rgb_q;

  always_comb begin
    rgb_c = BG_RGB;
    if (!active_s1) begin
      rgb_c = 12'h000;
    end else if (ball_s1) begin
      rgb_c = BALL_RGB;
`ifdef BALL_RENDERER_BORDER_EN
    end else if (border_s1) begin
      rgb_c = 12'hFFF;
`endif
    end
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q     <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_q     <= rgb_c;
      hsync_out <= hsync_s1;
      vsync_out <= vsync_s1;
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: doc/ball_renderer.md
# ball_renderer

Pixel-generation stage that sits directly downstream of the VGA timing generator. It consumes `hcount`/`vcount`/`hsync`/`vsync` and produces 12-bit RGB together with sync outputs delayed to match. It draws a square ball on a solid background. The ball's position advances once per frame during vertical blanking and bounces off the screen edges.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines per frame
- `BALL_SIZE`, 16, ball edge length in pixels
- `SPEED`, 2, pixels moved per frame on each axis (1..15)
- `BALL_RGB`, 12'hF80, ball colour {R,G,B}
- `BG_RGB`, 12'h008, background colour

Ports:
- `pxl_clk` in 1: pixel clock
- `reset_n` in 1: reset, asynchronous, active-low
- `hcount` in 10: horizontal pixel count from the timing generator
- `vcount` in 10: line count from the timing generator
- `hsync_in` in 1: horizontal sync from the timing generator
- `vsync_in` in 1: vertical sync from the timing generator
- `run` in 1: motion enable, level, sampled only on `frame_tick`
- `red`, `green`, `blue` out 4 each: pixel colour
- `hsync_out`, `vsync_out` out 1: syncs delayed to align with RGB
- `frame_tick` out 1: one-cycle pulse at the start of vertical blanking
- `bounce` out 1: one-cycle pulse when any wall reflection occurs
- `ball_x`, `ball_y` out 10: top-left corner of the ball

## Operation
- Wall limits:
  - XMIN = YMIN = B.
  - XMAX = H_ACTIVE - B - BALL_SIZE.
  - YMAX = V_ACTIVE - B - BALL_SIZE.
  - B = 8 when BORDER_EN is defined, else 0.
- Direction bits `dx`, `dy`: 0 = +, 1 = -.
- Frame tick:
  - Internal `vcount_d` register.
  - `frame_tick` is a registered pulse that goes high the cycle after `vcount` becomes V_ACTIVE, i.e. the previous value differs and the current value equals V_ACTIVE.
  - Exactly one pulse per frame. A vcount held at V_ACTIVE does not retrigger.
- FSM, evaluated only in cycles where `frame_tick` = 1:
  - IDLE: entered only from reset. Ball is centred and stationary. `run` = 1 goes to MOVE; no movement on this tick.
  - MOVE: `run` = 1 applies a position update. `run` = 0 goes to PAUSE with no update.
  - PAUSE: ball is held, not recentred. `run` = 1 goes to MOVE; no movement on this tick.
- Position update, per axis independently, using 11-bit intermediate arithmetic (no wrap):
  - Moving +: n = pos + SPEED. If n >= MAX, then pos = MAX, direction flips, and `bounce` is raised. Otherwise pos = n.
  - Moving -: if pos <= MIN + SPEED, then pos = MIN, direction flips, and `bounce` is raised. Otherwise pos = pos - SPEED.
  - A corner hit flips both directions in the same update and produces a single `bounce` pulse.
- `ball_x`, `ball_y`, `dx`, `dy` and `bounce` all register together at the end of the `frame_tick` cycle.
- Because updates occur only during vblank, no frame shows a torn ball.
- Pixel colour priority:
  1. Outside the active area (hcount >= H_ACTIVE or vcount >= V_ACTIVE): 12'h000.
  2. Ball: ball_x <= hcount < ball_x + BALL_SIZE and ball_y <= vcount < ball_y + BALL_SIZE → BALL_RGB.
  3. Border (BORDER_EN only) → 12'hFFF.
  4. Otherwise BG_RGB.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the active, ball-hit and border-hit compares, plus syncs delayed by 1.
  - Stage 2 registers RGB and the syncs.
- RGB and both sync outputs have a latency of exactly 2 `pxl_clk` cycles from their inputs.
- Sync polarity passes through unchanged.
- Reset values, applied asynchronously:
  - RGB = 0, `hsync_out` = 0, `vsync_out` = 0, `frame_tick` = 0, `bounce` = 0.
  - `ball_x` = (H_ACTIVE - BALL_SIZE)/2 = 312, `ball_y` = (V_ACTIVE - BALL_SIZE)/2 = 232.
  - `dx` = `dy` = 0; FSM = IDLE; pipeline and `vcount_d` cleared.
- Reset asserted mid-frame or mid-move returns the block to IDLE and the centre position immediately.
- Within 2 cycles of reset release, the outputs track the inputs.
- `run` changes between ticks are ignored. Only the value present on the tick cycle matters.

## Configuration
- `BALL_RENDERER_BORDER_EN`:
  - Defined: an 8-pixel white (12'hFFF) frame is drawn inside the active area, and the wall limits move inward by 8 on every side.
  - Undefined: no border; walls sit at the screen edge; the border compare logic is absent.

## Test plan
- Latency: drive hcount 0..799 with hsync_in high over 656..751 → hsync_out is high exactly 2 cycles later for 96 cycles; red/green/blue = 4'h0 at hcount 640..799 (+2 cycles).
- Frame tick: step vcount 479→480 and hold at 480 for 800 cycles → `frame_tick` gives exactly one 1-cycle pulse, on the cycle after 480 first appears.
- Movement: reset, run = 1, then 1 tick (IDLE→MOVE, ball stays at 312/232) and 1 more tick → ball_x = 314, ball_y = 234.
- Bounce, BORDER_EN undefined: run continuously → after 116 movement ticks ball_y = 464 with `bounce` = 1 and dy = 1; next tick ball_y = 462. After 156 movement ticks ball_x = 624 with `bounce` = 1.
- Pause/reset: run = 0 on a tick while in MOVE at x = 320 → position holds for 10 frames; then assert reset_n low mid-line → RGB = 0 and position = 312/232 immediately.
- Pixel check with BORDER_EN: at hcount = 3, vcount = 100 → 12'hFFF; at ball_x, ball_y → 12'hF80; at 100/100 → 12'h008; walls are 8 and 616/456.
